// File: rtl/cpu_pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
// Holds the FSM state encoding, the default flush length and the debug
// view of the controller's internal state.
package cpu_pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HALT  = 2'd3
    } pipe_state_e;

    // Cycles flush_flag is held per mispredict (legal 1..7).
    localparam int FLUSH_CYC_DEF = 2;

    // Debug snapshot of controller state for checkers.
    typedef struct packed {
        pipe_state_e state;
        logic [2:0]  flush_cnt;
        logic        pred_id;
        logic        pred_exe;
    } pipe_dbg_t;

    // A write to rd collides with a read of rs; x0 never collides.
    function automatic logic reg_match(input logic [4:0] rs,
                                       input logic [4:0] rd,
                                       input logic       we);
        return we && (rd == rs) && (rs != 5'd0);
    endfunction

endpackage

// File: rtl/cpu_pipe_ctrl_if.sv
// Pipeline-side signal bundle between the core datapath (master) and the
// sequencing controller (slave).
//
// Handshake semantics: there is no backpressure on the status inputs.
// br_valid qualifies br_taken for exactly the cycle it is high. The
// controller's wait_exe / wait_jmp / flush_flag outputs act as the
// not-ready side for fetch: whenever any of them is high, fetch must not
// advance the PC in that same cycle.
interface cpu_pipe_ctrl_if;
    logic       jmp_pred;
    logic       jmp_reg_en;
    logic [4:0] jmp_rs;
    logic [4:0] id_rd;
    logic [4:0] exe_rd;
    logic       id_we;
    logic       exe_we;
    logic       exe_busy;
    logic       br_valid;
    logic       br_taken;
    logic       running;
    logic       flush_flag;
    logic       wait_exe;
    logic       wait_jmp;

    modport master (
        output jmp_pred, jmp_reg_en, jmp_rs, id_rd, exe_rd, id_we, exe_we,
               exe_busy, br_valid, br_taken,
        input  running, flush_flag, wait_exe, wait_jmp
    );

    modport slave (
        input  jmp_pred, jmp_reg_en, jmp_rs, id_rd, exe_rd, id_we, exe_we,
               exe_busy, br_valid, br_taken,
        output running, flush_flag, wait_exe, wait_jmp
    );
endinterface

// File: rtl/cpu_hazard_cmp.sv
// Purely combinational register hazard comparator: flags when a source
// register is the pending destination of decode or execute. Also intended
// for operand-forwarding selection.
module cpu_hazard_cmp
    import cpu_pipe_ctrl_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] id_rd,
    input  logic       id_we,
    input  logic [4:0] exe_rd,
    input  logic       exe_we,
    output logic       hazard
);

    // Hazard if either in-flight stage will write the register being read.
    assign hazard = reg_match(rs, id_rd, id_we) | reg_match(rs, exe_rd, exe_we);

endmodule

// File: rtl/cpu_pipe_ctrl.sv
// Pipeline sequencing controller for the RV32 core.
// Drives running / flush_flag / wait_exe / wait_jmp, tracks static jump
// predictions from fetch to execute and sequences a fixed-length flush on
// mispredict. Optional performance counters are enabled by defining
// PIPE_PERF_EN; otherwise the perf ports read as zero.
module cpu_pipe_ctrl
    import cpu_pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYC = FLUSH_CYC_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               halt_req,
    cpu_pipe_ctrl_if.slave     bus,
    output logic [31:0]        perf_cyc,
    output logic [31:0]        perf_flush,
    output logic [31:0]        perf_stall,
    output pipe_dbg_t          dbg
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYC - 1);

    pipe_state_e state;
    logic        running_q;
    logic        flush_q;
    logic [2:0]  flush_cnt;
    logic        pred_id;
    logic        pred_exe;
    logic        jmp_hazard;
    logic        in_run;
    logic        advance;
    logic        mispredict;

    cpu_hazard_cmp u_hazard_cmp (
        .rs     (bus.jmp_rs),
        .id_rd  (bus.id_rd),
        .id_we  (bus.id_we),
        .exe_rd (bus.exe_rd),
        .exe_we (bus.exe_we),
        .hazard (jmp_hazard)
    );

    // Stall outputs are zero-latency: inputs gated only by registered state.
    assign in_run       = (state == ST_RUN);
    assign bus.wait_exe = in_run & bus.exe_busy;
    assign bus.wait_jmp = in_run & ~bus.exe_busy & bus.jmp_reg_en & jmp_hazard;
    assign bus.running    = running_q;
    assign bus.flush_flag = flush_q;

    assign advance    = running_q & ~bus.wait_exe & ~bus.wait_jmp & ~flush_q;
    assign mispredict = in_run & bus.br_valid & (bus.br_taken != pred_exe);

    assign dbg = '{state: state, flush_cnt: flush_cnt,
                   pred_id: pred_id, pred_exe: pred_exe};

    // Sequencing FSM with registered running/flush outputs and the
    // prediction pipeline that follows instructions from fetch to execute.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            running_q <= 1'b0;
            flush_q   <= 1'b0;
            flush_cnt <= 3'd0;
            pred_id   <= 1'b0;
            pred_exe  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_HALT: begin
                    if (start) begin
                        state     <= ST_RUN;
                        running_q <= 1'b1;
                        flush_q   <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (halt_req) begin
                        state     <= ST_HALT;
                        running_q <= 1'b0;
                        flush_q   <= 1'b0;
                        pred_id   <= 1'b0;
                        pred_exe  <= 1'b0;
                    end else if (mispredict) begin
                        state     <= ST_FLUSH;
                        flush_q   <= 1'b1;
                        flush_cnt <= FLUSH_LOAD;
                        pred_id   <= 1'b0;
                        pred_exe  <= 1'b0;
                    end else if (advance) begin
                        pred_id  <= bus.jmp_pred;
                        pred_exe <= pred_id;
                    end
                end
                ST_FLUSH: begin
                    // The halting instruction is older than anything flushed.
                    if (halt_req) begin
                        state     <= ST_HALT;
                        running_q <= 1'b0;
                        flush_q   <= 1'b0;
                        pred_id   <= 1'b0;
                        pred_exe  <= 1'b0;
                    end else if (flush_cnt == 3'd0) begin
                        state   <= ST_RUN;
                        flush_q <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt - 3'd1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    running_q <= 1'b0;
                    flush_q   <= 1'b0;
                end
            endcase
        end
    end

`ifdef PIPE_PERF_EN
    logic flush_enter;
    assign flush_enter = mispredict & ~halt_req;

    // Free-running wrap-around performance counters, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cyc   <= 32'd0;
            perf_flush <= 32'd0;
            perf_stall <= 32'd0;
        end else begin
            if (running_q)                      perf_cyc   <= perf_cyc + 32'd1;
            if (flush_enter)                    perf_flush <= perf_flush + 32'd1;
            if (bus.wait_exe | bus.wait_jmp)    perf_stall <= perf_stall + 32'd1;
        end
    end
`else
    assign perf_cyc   = 32'd0;
    assign perf_flush = 32'd0;
    assign perf_stall = 32'd0;
`endif

endmodule

// File: tb/tb_cpu_pipe_ctrl.sv
// Testbench for cpu_pipe_ctrl: directed steps from the test plan followed by
// a randomized phase, all checked against a behavioural model of the
// controller's rules.
module tb_cpu_pipe_ctrl;
    import cpu_pipe_ctrl_pkg::*;

    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        halt_req;
    logic [31:0] perf_cyc;
    logic [31:0] perf_flush;
    logic [31:0] perf_stall;
    pipe_dbg_t   dbg;

    cpu_pipe_ctrl_if bus();

    cpu_pipe_ctrl #(.FLUSH_CYC(FC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .halt_req   (halt_req),
        .bus        (bus),
        .perf_cyc   (perf_cyc),
        .perf_flush (perf_flush),
        .perf_stall (perf_stall),
        .dbg        (dbg)
    );

    // Clock
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: program running or not, halted flag, remaining
    // flush cycles, and predictions of the instructions in decode / execute.
    bit          m_run;
    bit          m_halted;
    int          m_flush_left;
    bit          m_pid;
    bit          m_pexe;
    logic [31:0] m_cyc;
    logic [31:0] m_fl;
    logic [31:0] m_st;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_wait_exe();
        return m_run && (m_flush_left == 0) && (bus.exe_busy === 1'b1);
    endfunction

    function automatic bit exp_wait_jmp();
        bit hit;
        hit = (bus.jmp_rs != 5'd0) &&
              ((bus.id_we && bus.id_rd == bus.jmp_rs) ||
               (bus.exe_we && bus.exe_rd == bus.jmp_rs));
        return m_run && (m_flush_left == 0) && !bus.exe_busy && bus.jmp_reg_en && hit;
    endfunction

    function automatic pipe_state_e exp_state();
        if (!m_run) return m_halted ? ST_HALT : ST_IDLE;
        return (m_flush_left > 0) ? ST_FLUSH : ST_RUN;
    endfunction

    task automatic model_reset();
        m_run = 0; m_halted = 0; m_flush_left = 0;
        m_pid = 0; m_pexe = 0;
        m_cyc = '0; m_fl = '0; m_st = '0;
    endtask

    task automatic model_step();
        bit we, wj;
        we = exp_wait_exe();
        wj = exp_wait_jmp();
`ifdef PIPE_PERF_EN
        if (m_run)    m_cyc = m_cyc + 1;
        if (we || wj) m_st  = m_st + 1;
`endif
        if (!m_run) begin
            if (start) begin m_run = 1; m_halted = 0; m_flush_left = 0; end
        end else if (halt_req) begin
            m_run = 0; m_halted = 1; m_flush_left = 0; m_pid = 0; m_pexe = 0;
        end else if (m_flush_left > 0) begin
            m_flush_left--;
        end else if (bus.br_valid && (bus.br_taken != m_pexe)) begin
            m_flush_left = FC; m_pid = 0; m_pexe = 0;
`ifdef PIPE_PERF_EN
            m_fl = m_fl + 1;
`endif
        end else if (!we && !wj) begin
            m_pexe = m_pid;
            m_pid  = bus.jmp_pred;
        end
    endtask

    task automatic check_all();
        chk("running",    32'(bus.running),    32'(m_run));
        chk("flush_flag", 32'(bus.flush_flag), 32'(m_flush_left > 0));
        chk("wait_exe",   32'(bus.wait_exe),   32'(exp_wait_exe()));
        chk("wait_jmp",   32'(bus.wait_jmp),   32'(exp_wait_jmp()));
        chk("state",      32'(dbg.state),      32'(exp_state()));
        chk("pred_id",    32'(dbg.pred_id),    32'(m_pid));
        chk("pred_exe",   32'(dbg.pred_exe),   32'(m_pexe));
        chk("perf_cyc",   perf_cyc,            m_cyc);
        chk("perf_flush", perf_flush,          m_fl);
        chk("perf_stall", perf_stall,          m_st);
    endtask

    // Driver: called at a negedge with inputs set; checks, advances model,
    // lets one rising edge pass, drops one-cycle pulses, returns at negedge.
    task automatic tick();
        #1;
        check_all();
        model_step();
        @(posedge clk);
        #1;
        start = 0; halt_req = 0; bus.br_valid = 0; bus.br_taken = 0;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        start = 0; halt_req = 0;
        bus.jmp_pred = 0; bus.jmp_reg_en = 0; bus.jmp_rs = '0;
        bus.id_rd = '0; bus.exe_rd = '0; bus.id_we = 0; bus.exe_we = 0;
        bus.exe_busy = 0; bus.br_valid = 0; bus.br_taken = 0;
    endtask

    // Asserts reset between edges and checks the asynchronous clear.
    task automatic async_reset(input string tag);
        #2;
        rst_n = 0;
        #1;
        chk({tag, "_running"},  32'(bus.running),    32'd0);
        chk({tag, "_flush"},    32'(bus.flush_flag), 32'd0);
        chk({tag, "_wait_exe"}, 32'(bus.wait_exe),   32'd0);
        chk({tag, "_wait_jmp"}, 32'(bus.wait_jmp),   32'd0);
        chk({tag, "_state"},    32'(dbg.state),      32'(ST_IDLE));
        chk({tag, "_perf_cyc"}, perf_cyc,            32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
    endtask

    logic [31:0] stall_base;

    initial begin
        rst_n = 0;
        idle_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1;

        // Reset state, then start at cycle 3.
        repeat (3) tick();
        chk("idle_before_start", 32'(bus.running), 32'd0);
        start = 1;
        tick();
        chk("run_after_start", 32'(bus.running), 32'd1);
        tick();

        // Predicted-taken branch that resolves not-taken two advances later.
        bus.jmp_pred = 1;
        tick();
        bus.jmp_pred = 0;
        tick();
        chk("pred_exe_taken", 32'(dbg.pred_exe), 32'd1);
        bus.br_valid = 1; bus.br_taken = 0;
        tick();
        chk("flush_c1", 32'(bus.flush_flag), 32'd1);
        bus.br_valid = 1; bus.br_taken = 1;   // ignored during flush
        tick();
        chk("flush_c2", 32'(bus.flush_flag), 32'd1);
        tick();
        chk("flush_done", 32'(bus.flush_flag), 32'd0);
`ifdef PIPE_PERF_EN
        chk("perf_flush_one", perf_flush, 32'd1);
`endif

        // Jump operand hazard against execute, then via x0.
        bus.jmp_reg_en = 1; bus.jmp_rs = 5'd5; bus.exe_we = 1; bus.exe_rd = 5'd5;
        #1;
        chk("wjmp_hit", 32'(bus.wait_jmp), 32'd1);
        tick();
        bus.jmp_rs = 5'd0; bus.exe_rd = 5'd0;
        #1;
        chk("wjmp_x0", 32'(bus.wait_jmp), 32'd0);
        tick();

        // Execute busy masks a concurrent jump hazard.
        stall_base = m_st;
        bus.jmp_rs = 5'd5; bus.exe_rd = 5'd5; bus.exe_busy = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("busy_wait_exe", 32'(bus.wait_exe), 32'd1);
            chk("busy_wait_jmp", 32'(bus.wait_jmp), 32'd0);
            tick();
        end
        bus.exe_busy = 0;
        #1;
        chk("after_busy_wait_jmp", 32'(bus.wait_jmp), 32'd1);
        tick();
        bus.jmp_reg_en = 0; bus.exe_we = 0;
        tick();
`ifdef PIPE_PERF_EN
        chk("perf_stall_four", perf_stall, stall_base + 32'd4);
`endif

        // Mispredict, then halt on the first flush cycle; restart.
        bus.jmp_pred = 1;
        tick();
        bus.jmp_pred = 0;
        tick();
        bus.br_valid = 1; bus.br_taken = 0;
        tick();
        halt_req = 1;
        tick();
        chk("halt_running", 32'(bus.running),    32'd0);
        chk("halt_flush",   32'(bus.flush_flag), 32'd0);
        chk("halt_state",   32'(dbg.state),      32'(ST_HALT));
        bus.jmp_pred = 1;
        tick();
        start = 1;
        tick();
        chk("restart_state", 32'(dbg.state),    32'(ST_RUN));
        chk("restart_pid",   32'(dbg.pred_id),  32'd0);
        chk("restart_pexe",  32'(dbg.pred_exe), 32'd0);
        bus.jmp_pred = 0;
        tick();

        // Reset mid-flush.
        bus.jmp_pred = 1;
        tick();
        bus.jmp_pred = 0;
        tick();
        bus.br_valid = 1; bus.br_taken = 0;
        tick();
        async_reset("rst_flush");
        tick();
        chk("post_rst_state", 32'(dbg.state), 32'(ST_IDLE));

        // Reset mid-stall.
        start = 1;
        tick();
        bus.exe_busy = 1;
        #1;
        chk("pre_rst_wait_exe", 32'(bus.wait_exe), 32'd1);
        async_reset("rst_stall");
        bus.exe_busy = 0;
        tick();

        // Randomized phase.
        for (int n = 0; n < 600; n++) begin
            bus.jmp_pred   = 1'($urandom_range(0, 1));
            bus.jmp_reg_en = 1'($urandom_range(0, 1));
            bus.jmp_rs     = 5'($urandom_range(0, 3));
            bus.id_rd      = 5'($urandom_range(0, 3));
            bus.exe_rd     = 5'($urandom_range(0, 3));
            bus.id_we      = 1'($urandom_range(0, 1));
            bus.exe_we     = 1'($urandom_range(0, 1));
            bus.exe_busy   = ($urandom_range(0, 3) == 0);
            bus.br_valid   = ($urandom_range(0, 4) == 0);
            bus.br_taken   = 1'($urandom_range(0, 1));
            halt_req       = ($urandom_range(0, 39) == 0);
            start          = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 199) == 0) begin
                async_reset("rst_rand");
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
